// File: rtl/snax_reshuffler_stream_fifo.sv
// Elastic beat buffer between streamer read port and data reshuffler input.
// Forwards a CSR-programmed number of beats and reports busy/beat/cycle counts.
module snax_reshuffler_stream_fifo #(
    parameter int DataWidth = 512,
    parameter int Depth     = 4,
    parameter int CntWidth  = 32,
    localparam int AddrWidth = $clog2(Depth),
    localparam int LvlWidth  = $clog2(Depth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    input  logic [CntWidth-1:0]  cfg_beats_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CntWidth-1:0]  beat_cnt_o,
    output logic [CntWidth-1:0]  cycle_cnt_o,
    output logic [LvlWidth-1:0]  level_o
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [LvlWidth-1:0]  r_wr_cnt;
    logic [LvlWidth-1:0]  r_rd_cnt;
    logic [CntWidth-1:0]  r_in_rem;
    logic [CntWidth-1:0]  r_out_rem;
    logic [CntWidth-1:0]  r_beat_cnt;
    logic [CntWidth-1:0]  r_cycle_cnt;
    logic                 r_done;

    logic [LvlWidth-1:0]  w_level;
    logic [AddrWidth-1:0] w_wr_ptr;
    logic [AddrWidth-1:0] w_rd_ptr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_run;
    logic                 w_cfg_ready;
    logic                 w_cfg_fire;
    logic                 w_cfg_zero;
    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_pop;
    logic                 w_done_nxt;

    // Occupancy counters carry one extra bit so full and empty are distinct.
    assign w_level  = r_wr_cnt - r_rd_cnt;
    assign w_wr_ptr = r_wr_cnt[AddrWidth-1:0];
    assign w_rd_ptr = r_rd_cnt[AddrWidth-1:0];
    assign w_full   = (w_level == LvlWidth'(Depth));
    assign w_empty  = (w_level == '0);

    assign w_in_ready = w_run & (r_in_rem != '0) & ~w_full;
    assign w_push     = in_valid_i & w_in_ready;
    assign w_pop      = ~w_empty & out_ready_i;
    assign w_cfg_fire = cfg_valid_i & w_cfg_ready;
    assign w_cfg_zero = w_cfg_fire & (cfg_beats_i == '0);
    assign w_last_pop = w_run & w_pop & (r_out_rem == CntWidth'(1));
    assign w_done_nxt = w_cfg_zero | w_last_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_cfg_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                if (w_cfg_fire && !w_cfg_zero) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (w_last_pop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_cnt <= r_wr_cnt + LvlWidth'(1);
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + LvlWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_rem  <= '0;
            r_out_rem <= '0;
        end else if (w_cfg_fire) begin
            r_in_rem  <= cfg_beats_i;
            r_out_rem <= cfg_beats_i;
        end else begin
            if (w_push) begin
                r_in_rem <= r_in_rem - CntWidth'(1);
            end
            if (w_pop && w_run) begin
                r_out_rem <= r_out_rem - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_beat_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else if (w_cfg_fire) begin
            r_beat_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else if (w_run) begin
            if (r_cycle_cnt != '1) begin
                r_cycle_cnt <= r_cycle_cnt + CntWidth'(1);
            end
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = ~w_empty;
    assign out_data_o  = w_empty ? '0 : r_mem[w_rd_ptr];
    assign cfg_ready_o = w_cfg_ready;
    assign busy_o      = w_run;
    assign done_o      = r_done;
    assign beat_cnt_o  = r_beat_cnt;
    assign cycle_cnt_o = r_cycle_cnt;
    assign level_o     = w_level;

endmodule

// File: tb/tb_snax_reshuffler_stream_fifo.sv
// Directed bench for snax_reshuffler_stream_fifo: ordering, latency,
// backpressure, zero-length config, excess beats, random stalls, reset.
module tb_snax_reshuffler_stream_fifo;

    localparam int DW = 512;
    localparam int CW = 32;
    localparam int LW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] cfg_beats_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] beat_cnt_o;
    logic [CW-1:0] cycle_cnt_o;
    logic [LW-1:0] level_o;

    snax_reshuffler_stream_fifo #(
        .DataWidth(DW),
        .Depth(4),
        .CntWidth(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .in_data_i(in_data_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .out_data_o(out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .cfg_beats_i(cfg_beats_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .beat_cnt_o(beat_cnt_o),
        .cycle_cnt_o(cycle_cnt_o),
        .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] base;
    logic [DW-1:0] rx_q[$];
    int n_push, n_done, max_lvl, first_push, first_ov;
    int done_cyc, last_pop, stall_cnt;
    int snap_push, snap_lvl, snap_ird;

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = base + 32'(k);
        return {16{w}};
    endfunction

    task automatic do_cfg(input int beats, output bit acc);
        cfg_valid_i = 1'b1;
        cfg_beats_i = CW'(beats);
        @(negedge clk_i);
        acc = cfg_ready_o;
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
    endtask

    // Drives source/sink for up to budget cycles and records what it saw.
    task automatic drive(input int offer, input int in_pct, input int out_pct,
                         input int delay, input int hold, input int budget);
        int sent;
        sent = 0;
        rx_q.delete();
        n_push = 0; n_done = 0; max_lvl = 0; stall_cnt = 0;
        first_push = -1; first_ov = -1; done_cyc = -1; last_pop = -1;
        snap_push = -1; snap_lvl = -1; snap_ird = -1;
        for (int c = 0; c < budget; c++) begin
            in_valid_i = (c >= delay) && (sent < offer)
                         && ($urandom_range(99) < in_pct);
            in_data_i = pat(sent);
            out_ready_i = (c >= hold) && ($urandom_range(99) < out_pct);
            @(negedge clk_i);
            if (c == hold - 1) begin
                snap_push = n_push;
                snap_lvl = int'(level_o);
                snap_ird = int'(in_ready_o);
            end
            if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
            if (out_valid_o && first_ov < 0) first_ov = c;
            if (done_o) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (in_valid_i && !in_ready_o) stall_cnt++;
            if (in_valid_i && in_ready_o) begin
                sent++;
                n_push++;
                if (first_push < 0) first_push = c;
            end
            if (out_valid_o && out_ready_i) begin
                rx_q.push_back(out_data_o);
                last_pop = c;
            end
            @(posedge clk_i);
            #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || cfg_ready_o !== 1'b1
            || busy_o !== 1'b0 || done_o !== 1'b0 || level_o !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ir=%b ov=%b cr=%b busy=%b done=%b lvl=%0d want 0 0 1 0 0 0",
                     in_ready_o, out_valid_o, cfg_ready_o, busy_o, done_o, level_o);
        end
        checks++;
        if (out_data_o !== '0 || beat_cnt_o !== '0 || cycle_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%h beat=%0d cyc=%0d want 0",
                     out_data_o[31:0], beat_cnt_o, cycle_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_basic;
        bit acc;
        int bad;
        base = 32'hA100_0000;
        do_cfg(4, acc);
        drive(4, 100, 100, 1, 0, 40);
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== pat(i)) bad++;
        checks++;
        if (!acc || rx_q.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL basic_data: acc=%0d n=%0d bad=%0d want 1 4 0", acc, rx_q.size(), bad);
        end
        checks++;
        if (first_push != 1 || first_ov != 2) begin
            errors++;
            $display("FAIL basic_latency: push=%0d ov=%0d want 1 2", first_push, first_ov);
        end
        checks++;
        if (n_done != 1 || done_cyc != last_pop + 1) begin
            errors++;
            $display("FAIL basic_done: n=%0d at=%0d want 1 at %0d", n_done, done_cyc, last_pop + 1);
        end
        checks++;
        if (beat_cnt_o !== 32'd4 || cycle_cnt_o !== 32'd6 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: beat=%0d cyc=%0d busy=%b want 4 6 0",
                     beat_cnt_o, cycle_cnt_o, busy_o);
        end
    endtask

    task automatic test_backpressure;
        bit acc;
        int bad;
        base = 32'hB200_0000;
        do_cfg(8, acc);
        drive(8, 100, 100, 0, 8, 60);
        checks++;
        if (snap_push != 4 || snap_lvl != 4 || snap_ird != 0) begin
            errors++;
            $display("FAIL bp_full: push=%0d lvl=%0d ir=%0d want 4 4 0", snap_push, snap_lvl, snap_ird);
        end
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== pat(i)) bad++;
        checks++;
        if (!acc || rx_q.size() != 8 || bad != 0) begin
            errors++;
            $display("FAIL bp_data: acc=%0d n=%0d bad=%0d want 1 8 0", acc, rx_q.size(), bad);
        end
        checks++;
        if (n_done != 1 || max_lvl > 4 || beat_cnt_o !== 32'd8) begin
            errors++;
            $display("FAIL bp_done: n=%0d maxlvl=%0d beat=%0d want 1 <=4 8", n_done, max_lvl, beat_cnt_o);
        end
    endtask

    task automatic test_zero_cfg;
        bit acc;
        do_cfg(0, acc);
        @(negedge clk_i);
        checks++;
        if (!acc || busy_o !== 1'b0 || done_o !== 1'b1 || beat_cnt_o !== '0 || cycle_cnt_o !== '0) begin
            errors++;
            $display("FAIL zero_cfg: acc=%0d busy=%b done=%b beat=%0d cyc=%0d want 1 0 1 0 0",
                     acc, busy_o, done_o, beat_cnt_o, cycle_cnt_o);
        end
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse: done=%b cr=%b want 0 1", done_o, cfg_ready_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_excess_beats;
        bit acc;
        int bad;
        base = 32'hC300_0000;
        do_cfg(3, acc);
        drive(5, 100, 100, 0, 0, 40);
        checks++;
        if (n_push != 3 || stall_cnt < 2) begin
            errors++;
            $display("FAIL excess_accept: push=%0d stalls=%0d want 3 >=2", n_push, stall_cnt);
        end
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== pat(i)) bad++;
        checks++;
        if (!acc || rx_q.size() != 3 || bad != 0) begin
            errors++;
            $display("FAIL excess_data: acc=%0d n=%0d bad=%0d want 1 3 0", acc, rx_q.size(), bad);
        end
        checks++;
        if (n_done != 1 || done_cyc != last_pop + 1 || beat_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL excess_done: n=%0d at=%0d beat=%0d want 1 at %0d 3",
                     n_done, done_cyc, beat_cnt_o, last_pop + 1);
        end
    endtask

    task automatic test_random;
        bit acc;
        int bad;
        base = 32'hD400_0000;
        do_cfg(100, acc);
        cfg_valid_i = 1'b1;
        cfg_beats_i = 32'd7;
        @(negedge clk_i);
        checks++;
        if (!acc || cfg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rand_cfg_busy: acc=%0d cr=%b want 1 0", acc, cfg_ready_o);
        end
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
        drive(100, 50, 50, 0, 0, 3000);
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== pat(i)) bad++;
        checks++;
        if (rx_q.size() != 100 || bad != 0) begin
            errors++;
            $display("FAIL rand_data: n=%0d bad=%0d want 100 0", rx_q.size(), bad);
        end
        checks++;
        if (n_done != 1 || max_lvl > 4 || beat_cnt_o !== 32'd100) begin
            errors++;
            $display("FAIL rand_done: n=%0d maxlvl=%0d beat=%0d want 1 <=4 100",
                     n_done, max_lvl, beat_cnt_o);
        end
    endtask

    task automatic test_reset_mid;
        bit acc;
        int bad;
        base = 32'hE500_0000;
        do_cfg(6, acc);
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = pat(0);
        @(posedge clk_i);
        #1;
        in_data_i = pat(1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (!acc || level_o !== 3'd2 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: acc=%0d lvl=%0d busy=%b want 1 2 1", acc, level_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || level_o !== '0 || out_valid_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: busy=%b lvl=%0d ov=%b cr=%b want 0 0 0 1",
                     busy_o, level_o, out_valid_o, cfg_ready_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        base = 32'hF600_0000;
        do_cfg(2, acc);
        drive(2, 100, 100, 0, 0, 40);
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== pat(i)) bad++;
        checks++;
        if (!acc || rx_q.size() != 2 || bad != 0 || n_done != 1 || beat_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL mid_after: acc=%0d n=%0d bad=%0d done=%0d beat=%0d want 1 2 0 1 2",
                     acc, rx_q.size(), bad, n_done, beat_cnt_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        in_data_i = '0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        cfg_beats_i = '0;
        cfg_valid_i = 1'b0;
        base = '0;
        test_reset;
        test_basic;
        test_backpressure;
        test_zero_cfg;
        test_excess_beats;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
